uart_vec_loader: RTL and testbench
==================================

// Module: uart_vec_loader
// PURPOSE
//  UART receiver + word assembler feeding the memory stage's user-data write port
//  (user_data_EN / user_data_in / address_b) of pipeline_top.
//  Receives 8N1 bytes on a serial line and packs WORD_BYTES bytes into one 128-bit
//  vector word. Issues one single-cycle write strobe per completed word, at an
//  auto-incrementing address. Lets a host preload vector data memory without resynthesis.
// PARAMETERS
//  CLK_FREQ      50_000_000  system clock frequency, Hz
//  BAUD          115200      serial bit rate
//  CLKS_PER_BIT  CLK_FREQ/BAUD  clocks per bit (localparam, must be >= 4)
//  WORD_BYTES    16          bytes per assembled word (128/8)
//  ADDR_W        16          width of write address
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       async reset, active-low
//  rx            in   1       serial input, idle high, asynchronous to clk
//  addr_clr      in   1       sync pulse: address <= 0, discard partial word
//  user_data_EN  out  1       one-cycle write strobe to memory stage
//  user_data_in  out  128     assembled word, valid while user_data_EN=1
//  address_b     out  ADDR_W  write address for current strobe
//  frame_err     out  1       one-cycle pulse, bad stop bit
//  byte_cnt      out  5       bytes held in partial word (0..WORD_BYTES-1)
//  busy          out  1       1 while RX FSM is not IDLE
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0, FSM=IDLE, address 0, byte_cnt 0,
//    sync flops preset to 1 (idle line).
//  - rx passes through a 2-FF synchronizer. All sampling uses the synced value.
//  - RX FSM: IDLE -> START on falling edge of synced rx.
//    START: wait CLKS_PER_BIT/2. If rx=1 there, treat as a false start and go to IDLE.
//    Otherwise go to DATA. DATA: 8 bits, LSB first, each sampled CLKS_PER_BIT later.
//    -> STOP: sample after CLKS_PER_BIT. Stop=1 accepts the byte; stop=0 drops it
//    and pulses frame_err. Return to IDLE either way.
//  - Packing is little-endian: byte k of a word goes to user_data_in[8k+7:8k].
//    First received byte is k=0.
//  - Accepted byte with byte_cnt<WORD_BYTES-1: store it, byte_cnt++.
//  - Accepted byte with byte_cnt=WORD_BYTES-1: on the next clk edge,
//    user_data_EN=1 for exactly one cycle, with the full word and the current address_b.
//    On the edge after that: address_b++, byte_cnt<=0, word register cleared.
//  - Latency: the strobe fires 1 cycle after the 16th stop-bit sample.
//  - Address wrap-around: 2^ADDR_W-1 -> 0, no flag.
//  - A frame error never changes byte_cnt or the stored bytes.
//  - addr_clr: takes effect next edge. Priority over a completing word, so that
//    word's strobe is suppressed. An in-flight serial byte continues and lands as byte 0.
//  - user_data_in is held at 0 whenever user_data_EN=0.
//  - Async reset mid-byte: FSM aborts at once, partial word lost.
// CONFIGURATION
//  UART_PARITY_EN defined: frame is 8E1. A PARITY state sits between DATA and STOP.
//    An even-parity mismatch drops the byte and pulses output parity_err
//    (1 bit, port exists only under the macro). The frame still finishes STOP.
//    If parity and stop bit are both bad, both flags pulse.
//  UART_PARITY_EN undefined: 8N1, no PARITY state, no parity_err port.
// TESTING (CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10)
//  1 Send 16 bytes 0x00..0x0F -> one strobe, address_b=0,
//    user_data_in=128'h0F0E..0100; address_b=1 the cycle after.
//  2 Send 0x55 with stop bit=0 -> frame_err pulse, byte_cnt unchanged, no strobe.
//  3 Glitch rx low for 3 clks -> returns to IDLE, busy drops, byte_cnt unchanged.
//  4 Preload address=16'hFFFF, send 16 bytes -> strobe at FFFF, then address_b=0.
//  5 Send 15 bytes, assert addr_clr during 16th byte's STOP -> no strobe,
//    address_b=0, byte_cnt=0.
//  6 UART_PARITY_EN: send 0x03 with parity=1 -> parity_err pulse, byte dropped.
//    With parity=0 -> byte accepted.

Source files
------------

// File: rtl/uart_vec_loader_if.sv
// Write port from the UART word loader into the memory stage's user-data port.
interface uart_vec_loader_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16
);
    logic              user_data_EN;
    logic [DATA_W-1:0] user_data_in;
    logic [ADDR_W-1:0] address_b;

    modport master (output user_data_EN, user_data_in, address_b);
    modport slave  (input  user_data_EN, user_data_in, address_b);
endinterface

// File: rtl/uart_vec_loader.sv
// UART receiver packing WORD_BYTES serial bytes into one vector word per write strobe.
// Define UART_PARITY_EN for 8E1 frames with a parity_err output; default is 8N1.
module uart_vec_loader #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int WORD_BYTES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              addr_clr,
    uart_vec_loader_if.master wr,
    output logic              frame_err,
`ifdef UART_PARITY_EN
    output logic              parity_err,
`endif
    output logic [4:0]        byte_cnt,
    output logic              busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (WORD_BYTES > 2) ? $clog2(WORD_BYTES - 1) : 1;
    localparam logic [4:0] LAST_IDX = 5'(WORD_BYTES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             rx_s1, rx_s2, rx_d;
    logic             byte_acc;
    logic             bit_end;
`ifdef UART_PARITY_EN
    logic             par_bad;
`endif

    logic [WORD_BYTES-2:0][7:0] word_q;

    assign busy    = (state != S_IDLE);
    assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Sync chain presets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            byte_acc   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            byte_acc  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                    end
                end
                S_START: begin
                    // Mid-start-bit check filters short glitches on the line.
                    if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_s2, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        par_bad <= (rx_s2 != ^shift_q);
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        state     <= S_IDLE;
                        frame_err <= !rx_s2;
`ifdef UART_PARITY_EN
                        parity_err <= par_bad;
                        byte_acc   <= rx_s2 && !par_bad;
`else
                        byte_acc   <= rx_s2;
`endif
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word assembly: strobe on the edge after the last byte lands, clean up on the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q          <= '0;
            byte_cnt        <= '0;
            wr.user_data_EN <= 1'b0;
            wr.user_data_in <= '0;
            wr.address_b    <= '0;
        end else begin
            wr.user_data_EN <= 1'b0;
            wr.user_data_in <= '0;
            if (addr_clr) begin
                wr.address_b <= '0;
                byte_cnt     <= '0;
                word_q       <= '0;
            end else if (wr.user_data_EN) begin
                wr.address_b <= wr.address_b + 1'b1;
                byte_cnt     <= '0;
                word_q       <= '0;
            end else if (byte_acc) begin
                if (byte_cnt == LAST_IDX) begin
                    wr.user_data_EN <= 1'b1;
                    wr.user_data_in <= {shift_q, word_q};
                end else begin
                    word_q[byte_cnt[IDX_W-1:0]] <= shift_q;
                    byte_cnt                    <= byte_cnt + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_vec_loader.sv
// Directed bench for uart_vec_loader: byte table plus hand sequences for strobe,
// wrap, addr_clr and reset corners. Small ADDR_W makes the all-ones wrap reachable.
module tb_uart_vec_loader;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int ADDR_W   = 2;
`ifdef UART_PARITY_EN
    localparam int FRAME_N  = 11;
`else
    localparam int FRAME_N  = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [4:0] exp_cnt;
        int         exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic addr_clr = 1'b0;
    logic frame_err;
    logic [4:0] byte_cnt;
    logic busy;
`ifdef UART_PARITY_EN
    logic parity_err;
    int   perr_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int ferr_cnt = 0;
    int hold_viol = 0;
    logic en_d = 1'b0;
    logic [127:0]      last_data = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [ADDR_W-1:0] post_addr = '0;

    uart_vec_loader_if #(.DATA_W(128), .ADDR_W(ADDR_W)) u_if ();

    uart_vec_loader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD_BYTES(16), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .addr_clr(addr_clr), .wr(u_if),
        .frame_err(frame_err),
`ifdef UART_PARITY_EN
        .parity_err(parity_err),
`endif
        .byte_cnt(byte_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.user_data_EN) begin
            strobes   = strobes + 1;
            last_data = u_if.user_data_in;
            last_addr = u_if.address_b;
        end else if (u_if.user_data_in != '0) begin
            hold_viol = hold_viol + 1;
        end
        if (en_d) post_addr = u_if.address_b;
        en_d = u_if.user_data_EN;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
`ifdef UART_PARITY_EN
        if (parity_err) perr_cnt = perr_cnt + 1;
`endif
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic stop_bit);
`ifdef UART_PARITY_EN
        return {1'b0, stop_bit, ^d, d, 1'b0};
`else
        return {2'b00, stop_bit, d, 1'b0};
`endif
    endfunction

    task automatic send_bits(input logic [11:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        send_bits(frame_bits(d, stop_bit), FRAME_N, 2 * CPB);
    endtask

    task automatic send_word(input logic [7:0] base, input logic [ADDR_W-1:0] exp_addr,
                             input logic [ADDR_W-1:0] exp_next);
        logic [127:0] exp;
        int s0;
        s0 = strobes;
        for (int k = 0; k < 16; k++) begin
            exp[8*k +: 8] = base + 8'(k);
            send_byte(base + 8'(k), 1'b1);
        end
        chk("word strobe count", 128'(strobes - s0), 128'd1);
        chk("word address", 128'(last_addr), 128'(exp_addr));
        chk("word data", last_data, exp);
        chk("address after strobe", 128'(post_addr), 128'(exp_next));
        chk("byte_cnt after word", 128'(byte_cnt), 128'd0);
    endtask

    initial begin
        vec_t tbl[4];
        logic [127:0] exp;
        int s0;
        tbl[0] = '{8'h55, 1'b0, 5'd0, 1};
        tbl[1] = '{8'hA5, 1'b1, 5'd1, 0};
        tbl[2] = '{8'h55, 1'b0, 5'd1, 1};
        tbl[3] = '{8'h3C, 1'b1, 5'd2, 0};

        repeat (3) @(negedge clk);
        chk("reset EN", 128'(u_if.user_data_EN), 128'd0);
        chk("reset data", u_if.user_data_in, 128'd0);
        chk("reset address", 128'(u_if.address_b), 128'd0);
        chk("reset byte_cnt", 128'(byte_cnt), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset frame_err", 128'(frame_err), 128'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Bytes 0x00..0x0F form one word at address 0.
        send_word(8'h00, 2'd0, 2'd1);
        chk("test1 literal word", last_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // Byte table: frame errors must leave byte_cnt and stored bytes alone.
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            int f0;
            f0 = ferr_cnt;
            send_byte(tbl[i].data, tbl[i].stop);
            chk($sformatf("vec%0d byte_cnt", i), 128'(byte_cnt), 128'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d frame_err pulses", i), 128'(ferr_cnt - f0), 128'(tbl[i].exp_ferr));
        end
        chk("table no strobe", 128'(strobes - s0), 128'd0);

        // 3-clock glitch: START entered, then abandoned.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        chk("glitch busy rises", 128'(busy), 128'd1);
        repeat (10) @(negedge clk);
        chk("glitch busy drops", 128'(busy), 128'd0);
        chk("glitch byte_cnt", 128'(byte_cnt), 128'd2);

        // Finish the partial word: bytes A5, 3C survive, then 0x10..0x1D.
        s0 = strobes;
        exp = '0;
        exp[7:0]  = 8'hA5;
        exp[15:8] = 8'h3C;
        for (int k = 2; k < 16; k++) begin
            exp[8*k +: 8] = 8'h10 + 8'(k - 2);
            send_byte(8'h10 + 8'(k - 2), 1'b1);
        end
        chk("mixed strobe count", 128'(strobes - s0), 128'd1);
        chk("mixed address", 128'(last_addr), 128'd1);
        chk("mixed data", last_data, exp);

        // Address wrap from all-ones to zero.
        send_word(8'h80, 2'd2, 2'd3);
        send_word(8'hC0, 2'd3, 2'd0);
        send_word(8'h40, 2'd0, 2'd1);

        // addr_clr held across the 16th byte's stop bit suppresses the strobe.
        for (int k = 0; k < 15; k++) send_byte(8'h60 + 8'(k), 1'b1);
        chk("15 bytes byte_cnt", 128'(byte_cnt), 128'd15);
        s0 = strobes;
        send_bits(frame_bits(8'h6F, 1'b1), FRAME_N - 1, 0);
        addr_clr = 1'b1;
        rx = 1'b1;
        repeat (CPB + 5) @(negedge clk);
        addr_clr = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("clr no strobe", 128'(strobes - s0), 128'd0);
        chk("clr address", 128'(u_if.address_b), 128'd0);
        chk("clr byte_cnt", 128'(byte_cnt), 128'd0);

        // addr_clr mid-byte: the in-flight byte lands as byte 0.
        send_byte(8'h11, 1'b1);
        chk("pre-clr byte_cnt", 128'(byte_cnt), 128'd1);
        send_bits(frame_bits(8'h77, 1'b1), 5, 0);
        rx = 1'b1;
        addr_clr = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        send_bits(frame_bits(8'h77, 1'b1) >> 5, FRAME_N - 5, 2 * CPB);
        chk("in-flight byte_cnt", 128'(byte_cnt), 128'd1);

        // Async reset mid-byte aborts the frame and the partial word.
        send_bits(frame_bits(8'h00, 1'b1), 4, 0);
        rx = 1'b0;
        chk("mid-byte busy", 128'(busy), 128'd1);
        #2 rst = 1'b0;
        #1;
        chk("async reset busy", 128'(busy), 128'd0);
        chk("async reset byte_cnt", 128'(byte_cnt), 128'd0);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("after reset idle", 128'(busy), 128'd0);

`ifdef UART_PARITY_EN
        begin
            int p0, f0;
            p0 = perr_cnt; f0 = ferr_cnt;
            send_bits({1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 2 * CPB);
            chk("bad parity pulse", 128'(perr_cnt - p0), 128'd1);
            chk("bad parity dropped", 128'(byte_cnt), 128'd0);
            p0 = perr_cnt;
            send_bits({1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 2 * CPB);
            chk("good parity no pulse", 128'(perr_cnt - p0), 128'd0);
            chk("good parity accepted", 128'(byte_cnt), 128'd1);
            p0 = perr_cnt;
            send_bits({1'b0, 1'b0, 1'b1, 8'h03, 1'b0}, 11, 2 * CPB);
            chk("both bad parity pulse", 128'(perr_cnt - p0), 128'd1);
            chk("both bad frame pulse", 128'(ferr_cnt - f0), 128'd1);
            chk("both bad dropped", 128'(byte_cnt), 128'd1);
        end
`endif

        chk("data zero outside strobe", 128'(hold_viol), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
